// File: rtl/instr_fetch_mem.sv
// Clocked instruction memory with a valid/ready fetch port, 1-cycle read latency,
// PC fault flags, sticky HALT detection and a run-time load port.
module instr_fetch_mem #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 32,
  parameter int          DEPTH   = 64,
  parameter logic [5:0]  HALT_OP = 6'b111111,
  localparam int         LA_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [LA_W-1:0]   load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_pc,
  output logic [1:0]        rsp_fault,
  output logic              halted
);

  localparam logic [1:0]        FLT_OK    = 2'b00;
  localparam logic [1:0]        FLT_ALIGN = 2'b01;
  localparam logic [1:0]        FLT_RANGE = 2'b10;
  localparam logic [LA_W:0]     DEPTH_LA  = (LA_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_PC  = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_instr_q, rsp_instr_d;
  logic [ADDR_W-1:0] rsp_pc_q,    rsp_pc_d;
  logic [1:0]        rsp_fault_q, rsp_fault_d;
  logic              halted_q,    halted_d;

  logic              accept, consume, halt_hit;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        fault_code;
  logic [DATA_W-1:0] rd_word;

  // Address decode and fault classification; misalignment outranks range.
  always_comb begin
    word_idx   = req_pc >> 2;
    fault_code = FLT_OK;
    if (req_pc[1:0] != 2'b00)       fault_code = FLT_ALIGN;
    else if (word_idx >= DEPTH_PC)  fault_code = FLT_RANGE;
    rd_word = (fault_code == FLT_OK) ? mem_q[word_idx[LA_W-1:0]] : '0;
  end

  always_comb begin
    req_ready = !halted_q && (!rsp_valid_q || rsp_ready);
    accept    = req_valid && req_ready;
    consume   = rsp_valid_q && rsp_ready;
    halt_hit  = consume && (rsp_fault_q == FLT_OK) &&
                (rsp_instr_q[DATA_W-1 -: 6] == HALT_OP);

    rsp_valid_d = rsp_valid_q;
    rsp_instr_d = rsp_instr_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_fault_d = rsp_fault_q;
    halted_d    = halted_q || halt_hit;

    // A consumed HALT freezes the port; a request offered alongside it is dropped.
    if (halt_hit) begin
      rsp_valid_d = 1'b0;
    end else if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_instr_d = rd_word;
      rsp_pc_d    = req_pc;
      rsp_fault_d = fault_code;
    end else if (consume) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= '0;
      rsp_pc_q    <= '0;
      rsp_fault_q <= FLT_OK;
      halted_q    <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_fault_q <= rsp_fault_d;
      halted_q    <= halted_d;
    end
  end

  // Load port is independent of reset; the read above sees the pre-write word.
  always_ff @(posedge clk) begin
    if (load_en && ({1'b0, load_addr} < DEPTH_LA)) begin
      mem_q[load_addr] <= load_data;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && consume) begin
      $display("ifm consume: pc=%h instr=%h code=%0d op=%b",
               rsp_pc_q, rsp_instr_q, rsp_fault_q, rsp_instr_q[DATA_W-1 -: 6]);
    end
  end
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_pc    = rsp_pc_q;
  assign rsp_fault = rsp_fault_q;
  assign halted    = halted_q;

endmodule
